pa_soc_itcm_arb: RTL and testbench

//  Arbitrates the single-port synchronous ITCM between the instruction-fetch (IF) port and the

---
 rtl/pa_soc_itcm_arb_pkg.sv | 18 +
 rtl/pa_soc_itcm_arb.sv | 134 +++++++++++++
 tb/tb_pa_soc_itcm_arb.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pa_soc_itcm_arb_pkg.sv
// Shared definitions for the ITCM arbiter: bus width, response-owner
// encodings and a byte-enable helper.
package pa_soc_itcm_arb_pkg;

    // Core data bus width; the ITCM data path matches it.
    localparam int DATA_BUS_WIDTH = 32;

    // Response-owner state encodings (2-bit, legacy-compatible constants).
    localparam logic [1:0] ITCM_OWN_NONE = 2'b00;
    localparam logic [1:0] ITCM_OWN_IF   = 2'b01;
    localparam logic [1:0] ITCM_OWN_LS   = 2'b10;

    // Stores use the requester's byte enables; every read fetches the full word.
    function automatic logic [3:0] itcm_be(input logic we, input logic [3:0] be);
        return we ? be : 4'hF;
    endfunction

endpackage

// File: rtl/pa_soc_itcm_arb.sv
// pa_soc_itcm_arb: single-port ITCM arbiter between instruction fetch (IF)
// and load/store (LS). One access per cycle, LS has priority, read data is
// steered back to the owner exactly one cycle after its grant.
//
// Optional build macro: ITCM_ARB_STARVE_EN
//   defined   -> IF is forced to win after STARVE_MAX consecutive denials
//   undefined -> strict LS priority, no starvation counter
//
// Handshake (both requester ports): a requester raises *_req_i and holds its
// address/data stable; the access is accepted in the cycle *_gnt_o is high
// (grant is combinational from the requests). Exactly one cycle later the
// owner sees *_rvalid_o for one cycle with its read data (0 for a store ack).
// Dropping *_req_i before a grant cancels the request with no response.
module pa_soc_itcm_arb
    import pa_soc_itcm_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = DATA_BUS_WIDTH,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    // instruction-fetch port
    input  logic                  if_req_i,
    input  logic [31:0]           if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    // load/store port
    input  logic                  ls_req_i,
    input  logic                  ls_we_i,
    input  logic [3:0]            ls_be_i,
    input  logic [31:0]           ls_addr_i,
    input  logic [DATA_WIDTH-1:0] ls_wdata_i,
    output logic                  ls_gnt_o,
    output logic                  ls_rvalid_o,
    output logic [DATA_WIDTH-1:0] ls_rdata_o,
    // SRAM port
    output logic                  mem_ce_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    // debug: current response owner state
    output logic [1:0]            dbg_resp_owner_o
);

    logic                  w_if_force;
    logic                  w_if_gnt;
    logic                  w_ls_gnt;
    logic [31:0]           w_gnt_addr;
    logic [1:0]            w_resp_owner_nxt;
    logic [1:0]            r_resp_owner;
    logic                  r_resp_store;
    logic                  w_unused_addr;

`ifdef ITCM_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] r_starve_cnt;

    // IF takes priority once it has been denied STARVE_MAX times in a row.
    assign w_if_force = (r_starve_cnt == CNT_W'(STARVE_MAX));

    // Count IF denials; clear on any IF grant; saturate at the threshold.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_starve_cnt <= '0;
        end else if (w_if_gnt) begin
            r_starve_cnt <= '0;
        end else if (if_req_i && (r_starve_cnt != CNT_W'(STARVE_MAX))) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end
`else
    logic w_unused_cfg;

    // Strict LS priority: IF is never forced ahead of a load/store.
    assign w_if_force   = 1'b0;
    assign w_unused_cfg = (STARVE_MAX > 0);
`endif

    // Arbitration: LS wins unless the starvation override is active.
    // No grants while reset is asserted.
    assign w_ls_gnt = rst_n_i & ls_req_i & ~(if_req_i & w_if_force);
    assign w_if_gnt = rst_n_i & if_req_i & (~ls_req_i | w_if_force);

    assign if_gnt_o = w_if_gnt;
    assign ls_gnt_o = w_ls_gnt;

    // SRAM drive: word address of the winner, upper address bits wrap.
    assign w_gnt_addr  = w_ls_gnt ? ls_addr_i : if_addr_i;
    assign mem_ce_o    = w_if_gnt | w_ls_gnt;
    assign mem_we_o    = w_ls_gnt & ls_we_i;
    assign mem_be_o    = w_ls_gnt ? itcm_be(ls_we_i, ls_be_i) : 4'hF;
    assign mem_addr_o  = w_gnt_addr[ADDR_WIDTH+1:2];
    assign mem_wdata_o = ls_wdata_i;

    // Byte-offset and out-of-range address bits are intentionally ignored.
    assign w_unused_addr = ^{if_addr_i[31:ADDR_WIDTH+2], if_addr_i[1:0],
                             ls_addr_i[31:ADDR_WIDTH+2], ls_addr_i[1:0]};

    // Next response owner follows this cycle's grant.
    always_comb begin
        w_resp_owner_nxt = ITCM_OWN_NONE;
        if (w_ls_gnt) begin
            w_resp_owner_nxt = ITCM_OWN_LS;
        end else if (w_if_gnt) begin
            w_resp_owner_nxt = ITCM_OWN_IF;
        end
    end

    // Response FSM: remember who owns the SRAM output next cycle, and
    // whether that access was a store (store acks return zero data).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_resp_owner <= ITCM_OWN_NONE;
            r_resp_store <= 1'b0;
        end else begin
            r_resp_owner <= w_resp_owner_nxt;
            r_resp_store <= w_ls_gnt & ls_we_i;
        end
    end

    // Response steering: only the owner sees valid and data.
    assign if_rvalid_o = (r_resp_owner == ITCM_OWN_IF);
    assign ls_rvalid_o = (r_resp_owner == ITCM_OWN_LS);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign ls_rdata_o  = (ls_rvalid_o && !r_resp_store) ? mem_rdata_i : '0;

    assign dbg_resp_owner_o = r_resp_owner;

endmodule

// File: tb/tb_pa_soc_itcm_arb.sv
// Directed testbench for pa_soc_itcm_arb with a behavioural 1-cycle SRAM.
// Build with +define+ITCM_ARB_STARVE_EN to exercise the starvation override.
module tb_pa_soc_itcm_arb;
    import pa_soc_itcm_arb_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SMAX = 4;
`ifdef ITCM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    // clock / reset
    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          if_req_i = 1'b0;
    logic [31:0]   if_addr_i = '0;
    logic          if_gnt_o, if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          ls_req_i = 1'b0;
    logic          ls_we_i = 1'b0;
    logic [3:0]    ls_be_i = 4'h0;
    logic [31:0]   ls_addr_i = '0;
    logic [DW-1:0] ls_wdata_i = '0;
    logic          ls_gnt_o, ls_rvalid_o;
    logic [DW-1:0] ls_rdata_o;
    logic          mem_ce_o, mem_we_o;
    logic [3:0]    mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i = '0;
    logic [1:0]    dbg_resp_owner_o;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] sram [0:(1<<AW)-1];

    pa_soc_itcm_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_MAX(SMAX)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i),
        .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
        .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .dbg_resp_owner_o(dbg_resp_owner_o)
    );

    // SRAM model: read-first, output is the old word even on a write cycle.
    always @(posedge clk_i) begin
        if (mem_ce_o) begin
            mem_rdata_i <= sram[mem_addr_o];
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be_o[b]) sram[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
                end
            end
        end
    end

    task automatic drive_idle();
        if_req_i = 1'b0;
        ls_req_i = 1'b0;
        ls_we_i  = 1'b0;
        ls_be_i  = 4'h0;
    endtask

    task automatic test_reset();
        rst_n_i   = 1'b0;
        if_req_i  = 1'b1;
        if_addr_i = 32'h10;
        ls_req_i  = 1'b1;
        ls_addr_i = 32'h20;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if ({if_gnt_o, ls_gnt_o, mem_ce_o, mem_we_o} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_gnt: if_gnt=%b ls_gnt=%b ce=%b we=%b, expected all 0",
                         if_gnt_o, ls_gnt_o, mem_ce_o, mem_we_o);
            end
            checks++;
            if ({if_rvalid_o, ls_rvalid_o} !== 2'b00 || if_rdata_o !== '0 || ls_rdata_o !== '0) begin
                errors++;
                $display("FAIL reset_resp: if_rv=%b ls_rv=%b if_rd=%h ls_rd=%h, expected 0",
                         if_rvalid_o, ls_rvalid_o, if_rdata_o, ls_rdata_o);
            end
            checks++;
            if (dbg_resp_owner_o !== ITCM_OWN_NONE) begin
                errors++;
                $display("FAIL reset_owner: got %0d expected %0d", dbg_resp_owner_o, ITCM_OWN_NONE);
            end
        end
        @(posedge clk_i); #1;
        drive_idle();
        rst_n_i = 1'b1;
    endtask

    task automatic test_if_read(input logic [31:0] addr, input logic [AW-1:0] exp_waddr,
                                input logic [DW-1:0] exp_data);
        @(posedge clk_i); #1;
        if_req_i  = 1'b1;
        if_addr_i = addr;
        @(negedge clk_i);
        checks++;
        if (if_gnt_o !== 1'b1 || ls_gnt_o !== 1'b0 || mem_ce_o !== 1'b1 || mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL if_read_gnt: if_gnt=%b ls_gnt=%b ce=%b we=%b, expected 1 0 1 0",
                     if_gnt_o, ls_gnt_o, mem_ce_o, mem_we_o);
        end
        checks++;
        if (mem_addr_o !== exp_waddr || mem_be_o !== 4'hF) begin
            errors++;
            $display("FAIL if_read_addr: addr=%h be=%h, expected %h F", mem_addr_o, mem_be_o, exp_waddr);
        end
        @(posedge clk_i); #1;
        drive_idle();
        @(negedge clk_i);
        checks++;
        if (if_rvalid_o !== 1'b1 || if_rdata_o !== exp_data || ls_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL if_read_resp: rv=%b data=%h ls_rv=%b, expected 1 %h 0",
                     if_rvalid_o, if_rdata_o, ls_rvalid_o, exp_data);
        end
        checks++;
        if (dbg_resp_owner_o !== ITCM_OWN_IF || mem_ce_o !== 1'b0) begin
            errors++;
            $display("FAIL if_read_owner: owner=%0d ce=%b, expected %0d 0",
                     dbg_resp_owner_o, mem_ce_o, ITCM_OWN_IF);
        end
    endtask

    task automatic test_simultaneous();
        @(posedge clk_i); #1;
        if_req_i  = 1'b1;
        if_addr_i = 32'h10;
        ls_req_i  = 1'b1;
        ls_we_i   = 1'b0;
        ls_addr_i = 32'h20;
        @(negedge clk_i);
        checks++;
        if (ls_gnt_o !== 1'b1 || if_gnt_o !== 1'b0 || mem_addr_o !== 12'd8) begin
            errors++;
            $display("FAIL simul_gnt: ls_gnt=%b if_gnt=%b addr=%h, expected 1 0 008",
                     ls_gnt_o, if_gnt_o, mem_addr_o);
        end
        @(posedge clk_i); #1;
        ls_req_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (ls_rvalid_o !== 1'b1 || ls_rdata_o !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL simul_ls_resp: rv=%b data=%h, expected 1 cafef00d", ls_rvalid_o, ls_rdata_o);
        end
        checks++;
        if (if_gnt_o !== 1'b1 || mem_addr_o !== 12'd4 || if_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL simul_if_gnt: if_gnt=%b addr=%h if_rv=%b, expected 1 004 0",
                     if_gnt_o, mem_addr_o, if_rvalid_o);
        end
        @(posedge clk_i); #1;
        drive_idle();
        @(negedge clk_i);
        checks++;
        if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h2402_0001 || ls_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL simul_if_resp: rv=%b data=%h ls_rv=%b, expected 1 24020001 0",
                     if_rvalid_o, if_rdata_o, ls_rvalid_o);
        end
    endtask

    task automatic test_store();
        @(posedge clk_i); #1;
        ls_req_i   = 1'b1;
        ls_we_i    = 1'b1;
        ls_be_i    = 4'b0011;
        ls_addr_i  = 32'h24;
        ls_wdata_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        checks++;
        if (ls_gnt_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 12'd9 ||
            mem_be_o !== 4'b0011 || mem_wdata_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL store_drive: gnt=%b we=%b addr=%h be=%h wd=%h, expected 1 1 009 3 deadbeef",
                     ls_gnt_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o);
        end
        @(posedge clk_i); #1;
        drive_idle();
        if_req_i  = 1'b1;
        if_addr_i = 32'h24;
        @(negedge clk_i);
        checks++;
        if (ls_rvalid_o !== 1'b1 || ls_rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL store_ack: rv=%b data=%h, expected 1 00000000", ls_rvalid_o, ls_rdata_o);
        end
        checks++;
        if (if_gnt_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 12'd9) begin
            errors++;
            $display("FAIL store_readback_gnt: gnt=%b we=%b addr=%h, expected 1 0 009",
                     if_gnt_o, mem_we_o, mem_addr_o);
        end
        @(posedge clk_i); #1;
        drive_idle();
        @(negedge clk_i);
        checks++;
        if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h1122_BEEF) begin
            errors++;
            $display("FAIL store_readback: rv=%b data=%h, expected 1 1122beef", if_rvalid_o, if_rdata_o);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk_i); #1;
        if_req_i  = 1'b1;
        if_addr_i = 32'h10;
        @(negedge clk_i);
        checks++;
        if (if_gnt_o !== 1'b1 || mem_addr_o !== 12'd4) begin
            errors++;
            $display("FAIL b2b_gnt0: gnt=%b addr=%h, expected 1 004", if_gnt_o, mem_addr_o);
        end
        @(posedge clk_i); #1;
        if_addr_i = 32'h20;
        @(negedge clk_i);
        checks++;
        if (if_gnt_o !== 1'b1 || mem_addr_o !== 12'd8 || if_rvalid_o !== 1'b1 ||
            if_rdata_o !== 32'h2402_0001) begin
            errors++;
            $display("FAIL b2b_cyc1: gnt=%b addr=%h rv=%b data=%h, expected 1 008 1 24020001",
                     if_gnt_o, mem_addr_o, if_rvalid_o, if_rdata_o);
        end
        @(posedge clk_i); #1;
        drive_idle();
        @(negedge clk_i);
        checks++;
        if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL b2b_cyc2: rv=%b data=%h, expected 1 cafef00d", if_rvalid_o, if_rdata_o);
        end
    endtask

    task automatic test_starve();
        int  cnt;
        bit  exp_if, exp_ls, prev_if, prev_ls;
        cnt = 0;
        prev_if = 1'b0;
        prev_ls = 1'b0;
        @(posedge clk_i); #1;
        ls_req_i  = 1'b1;
        ls_we_i   = 1'b0;
        ls_addr_i = 32'h20;
        if_req_i  = 1'b1;
        if_addr_i = 32'h10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            exp_if = STARVE_EN && (cnt == SMAX);
            exp_ls = !exp_if;
            checks++;
            if (if_gnt_o !== exp_if || ls_gnt_o !== exp_ls) begin
                errors++;
                $display("FAIL starve_gnt[%0d]: if_gnt=%b ls_gnt=%b, expected %b %b",
                         i, if_gnt_o, ls_gnt_o, exp_if, exp_ls);
            end
            checks++;
            if (mem_addr_o !== (exp_if ? 12'd4 : 12'd8)) begin
                errors++;
                $display("FAIL starve_addr[%0d]: addr=%h, expected %h",
                         i, mem_addr_o, exp_if ? 12'd4 : 12'd8);
            end
            checks++;
            if (if_rvalid_o !== prev_if || ls_rvalid_o !== prev_ls) begin
                errors++;
                $display("FAIL starve_rvalid[%0d]: if_rv=%b ls_rv=%b, expected %b %b",
                         i, if_rvalid_o, ls_rvalid_o, prev_if, prev_ls);
            end
            if (prev_ls) begin
                checks++;
                if (ls_rdata_o !== 32'hCAFE_F00D) begin
                    errors++;
                    $display("FAIL starve_ls_data[%0d]: got %h expected cafef00d", i, ls_rdata_o);
                end
            end
            if (prev_if) begin
                checks++;
                if (if_rdata_o !== 32'h2402_0001) begin
                    errors++;
                    $display("FAIL starve_if_data[%0d]: got %h expected 24020001", i, if_rdata_o);
                end
            end
            if (exp_if) cnt = 0;
            else if (cnt < SMAX) cnt++;
            prev_if = exp_if;
            prev_ls = exp_ls;
            @(posedge clk_i);
        end
        #1;
        drive_idle();
        @(negedge clk_i);
        checks++;
        if (if_rvalid_o !== prev_if || ls_rvalid_o !== prev_ls) begin
            errors++;
            $display("FAIL starve_tail: if_rv=%b ls_rv=%b, expected %b %b",
                     if_rvalid_o, ls_rvalid_o, prev_if, prev_ls);
        end
    endtask

    task automatic test_drop();
        @(posedge clk_i); #1;
        if_req_i  = 1'b1;
        if_addr_i = 32'h10;
        ls_req_i  = 1'b1;
        ls_we_i   = 1'b0;
        ls_addr_i = 32'h20;
        @(negedge clk_i);
        checks++;
        if (ls_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL drop_gnt: ls_gnt=%b if_gnt=%b, expected 1 0", ls_gnt_o, if_gnt_o);
        end
        @(posedge clk_i); #1;
        drive_idle();
        @(negedge clk_i);
        checks++;
        if (ls_rvalid_o !== 1'b1 || if_gnt_o !== 1'b0 || mem_ce_o !== 1'b0) begin
            errors++;
            $display("FAIL drop_cyc1: ls_rv=%b if_gnt=%b ce=%b, expected 1 0 0",
                     ls_rvalid_o, if_gnt_o, mem_ce_o);
        end
        @(negedge clk_i);
        checks++;
        if (if_rvalid_o !== 1'b0 || ls_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL drop_cyc2: if_rv=%b ls_rv=%b, expected 0 0", if_rvalid_o, ls_rvalid_o);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk_i); #1;
        if_req_i  = 1'b1;
        if_addr_i = 32'h24;
        @(negedge clk_i);
        checks++;
        if (if_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_gnt: if_gnt=%b expected 1", if_gnt_o);
        end
        rst_n_i = 1'b0;
        #1;
        checks++;
        if (if_gnt_o !== 1'b0 || mem_ce_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_gate: if_gnt=%b ce=%b, expected 0 0", if_gnt_o, mem_ce_o);
        end
        drive_idle();
        @(posedge clk_i); #1;
        checks++;
        if (if_rvalid_o !== 1'b0 || dbg_resp_owner_o !== ITCM_OWN_NONE) begin
            errors++;
            $display("FAIL rstmid_held: if_rv=%b owner=%0d, expected 0 0", if_rvalid_o, dbg_resp_owner_o);
        end
        rst_n_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            checks++;
            if (if_rvalid_o !== 1'b0 || ls_rvalid_o !== 1'b0 || if_rdata_o !== '0) begin
                errors++;
                $display("FAIL rstmid_release[%0d]: if_rv=%b ls_rv=%b if_rd=%h, expected 0 0 0",
                         i, if_rvalid_o, ls_rvalid_o, if_rdata_o);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) sram[i] = 32'hA5A5_0000 | i;
        sram[4] = 32'h2402_0001;
        sram[8] = 32'hCAFE_F00D;
        sram[9] = 32'h1122_3344;

        test_reset();
        test_if_read(32'h0000_0010, 12'd4, 32'h2402_0001);
        test_if_read(32'hFFFF_C013, 12'd4, 32'h2402_0001);
        test_simultaneous();
        test_store();
        test_back_to_back();
        test_starve();
        test_drop();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
